// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester, grant and output-stage signals of the 4-way packet arbiter
interface mux4_rr_arbiter_if #(parameter int MUX_DATA_WIDTH = 32);
  logic [3:0] i_req_valid;
  logic [3:0] i_req_last;
  logic [MUX_DATA_WIDTH-1:0] i_req_data0;
  logic [MUX_DATA_WIDTH-1:0] i_req_data1;
  logic [MUX_DATA_WIDTH-1:0] i_req_data2;
  logic [MUX_DATA_WIDTH-1:0] i_req_data3;
  logic [3:0] o_req_ready;
  logic [1:0] o_sel;
  logic o_busy;
  logic o_out_valid;
  logic [MUX_DATA_WIDTH-1:0] o_out_data;
  logic o_out_last;
  logic i_out_ready;
  modport slave (
    input i_req_valid, i_req_last, i_req_data0, i_req_data1, i_req_data2, i_req_data3, i_out_ready,
    output o_req_ready, o_sel, o_busy, o_out_valid, o_out_data, o_out_last
  );
  modport master (
    output i_req_valid, i_req_last, i_req_data0, i_req_data1, i_req_data2, i_req_data3, i_out_ready,
    input o_req_ready, o_sel, o_busy, o_out_valid, o_out_data, o_out_last
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin packet arbiter muxing four requesters into one registered output stage
module mux4_rr_arbiter #(
  parameter int MUX_DATA_WIDTH = 32
) (
  input logic i_clk,
  input logic i_rst,
  mux4_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_ptr, r_sel, w_off, w_win;
  logic [3:0] w_rot;
  logic w_open, w_xfer, w_last;
  logic [MUX_DATA_WIDTH-1:0] w_data, r_out_data;
  logic r_out_valid, r_out_last;
  always_comb begin
    w_rot = {bus.i_req_valid[r_ptr + 2'd3], bus.i_req_valid[r_ptr + 2'd2],
             bus.i_req_valid[r_ptr + 2'd1], bus.i_req_valid[r_ptr]};
    w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
    w_win = r_ptr + w_off;
    w_open = !i_rst && r_state == GRANT && (!r_out_valid || bus.i_out_ready);
    w_xfer = w_open && bus.i_req_valid[r_sel];
    w_last = bus.i_req_last[r_sel];
    w_data = r_sel == 2'd0 ? bus.i_req_data0 :
             r_sel == 2'd1 ? bus.i_req_data1 :
             r_sel == 2'd2 ? bus.i_req_data2 : bus.i_req_data3;
    w_next = r_state == IDLE ? (|bus.i_req_valid ? GRANT : IDLE) :
             (w_xfer && w_last ? IDLE : GRANT);
  end
  always_ff @(posedge i_clk) r_state <= i_rst ? IDLE : w_next;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 2'd0;
      r_sel <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (r_state == IDLE && |bus.i_req_valid) r_sel <= w_win;
      if (w_xfer && w_last) r_ptr <= r_sel + 2'd1;
      if (w_xfer) begin
        r_out_data <= w_data;
        r_out_last <= w_last;
        r_out_valid <= 1'b1;
      end else if (bus.i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
  assign bus.o_req_ready = w_open ? 4'b0001 << r_sel : 4'b0000;
  assign bus.o_sel = r_sel;
  assign bus.o_busy = r_state == GRANT;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_data = r_out_data;
  assign bus.o_out_last = r_out_last;
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MUX_DATA_WIDTH, default 32, giving the data width of every requester and of the output.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port i_req_valid, input, 4 bits: bit k set means requester k offers a beat.
REQ-005 The block SHALL have port i_req_last, input, 4 bits: bit k set means requester k's current beat ends its packet.
REQ-006 The block SHALL have ports i_req_data0 .. i_req_data3, each input, MUX_DATA_WIDTH bits: requester beat data.
REQ-007 The block SHALL have port o_req_ready, output, 4 bits: at most one bit set; bit k set means requester k's beat is accepted this cycle if valid.
REQ-008 The block SHALL have port o_sel, output, 2 bits: index of the granted requester, which selects the data path.
REQ-009 The block SHALL have port o_busy, output, 1 bit: a grant is held (state GRANT).
REQ-010 The block SHALL have port o_out_valid, output, 1 bit: the output register holds a beat.
REQ-011 The block SHALL have port o_out_data, output, MUX_DATA_WIDTH bits: the registered beat.
REQ-012 The block SHALL have port o_out_last, output, 1 bit: the registered beat ends its packet.
REQ-013 The block SHALL have port i_out_ready, input, 1 bit: the downstream consumer accepts the beat in the output register.

Function
REQ-014 The block SHALL implement a two-state FSM, IDLE and GRANT.
REQ-015 In IDLE with any i_req_valid bit set, the block SHALL pick the first set bit scanning circularly from priority pointer ptr.
- Example: ptr=2 scans 2,3,0,1.
- On the next edge it SHALL register the winner into o_sel and enter GRANT.
REQ-016 In IDLE, o_req_ready SHALL be 4'b0000.
REQ-017 In GRANT, o_req_ready[o_sel] SHALL equal (!o_out_valid || i_out_ready); all other ready bits SHALL be 0.
REQ-018 A beat SHALL transfer when i_req_valid[o_sel] and o_req_ready[o_sel] are both set.
- On the next edge the block SHALL load o_out_data with i_req_data[o_sel], load o_out_last with i_req_last[o_sel], and set o_out_valid=1.
REQ-019 When the transferred beat has last=1, the block SHALL return to IDLE and set ptr=o_sel+1 mod 4; o_sel SHALL hold its value.
REQ-020 When no beat transfers, o_out_valid SHALL clear on an edge where i_out_ready=1.
REQ-021 When a beat transfers on the same edge as i_out_ready=1 with o_out_valid=1, the new beat SHALL replace the old one and o_out_valid SHALL stay 1, with no bubble and no loss.
REQ-022 While in GRANT, the grant SHALL be held until the last beat even if i_req_valid[o_sel] deasserts; the grant SHALL NOT be preempted by other requesters.
REQ-023 Latency: request seen in IDLE at cycle N -> o_busy=1 at N+1 -> earliest o_out_valid=1 at N+2.
- Sustained throughput SHALL be 1 beat/cycle within a packet while i_out_ready=1.
- There SHALL be exactly 1 idle cycle between packets.
REQ-024 Holding i_out_ready=0 SHALL stall the upstream via o_req_ready with no data loss; o_out_data and o_out_last SHALL stay stable while o_out_valid=1 and i_out_ready=0.
REQ-025 The block SHALL be fair: with all four requesters continuously valid, grants SHALL rotate 0,1,2,3,0,... by packet.

Reset
REQ-026 With i_rst=1 at an edge, the block SHALL set state=IDLE, ptr=0, o_sel=0, o_busy=0, o_out_valid=0, o_out_data=0, and o_out_last=0.
- o_req_ready SHALL be 0 during and in the cycle after reset.
REQ-027 Reset asserted mid-packet SHALL abandon the packet and discard any beat held in the output register.
- The first grant after reset SHALL follow ptr=0 priority.

Verification
REQ-028 Single requester: i_req_valid=4'b0100 with a 1-beat packet, data 0xA5A5A5A5, last=1, i_out_ready=1 -> o_sel=2 and o_busy=1 at N+1; o_out_data=0xA5A5A5A5, o_out_valid=1, o_out_last=1 at N+2; ptr=3 afterwards.
REQ-029 All four requesters valid, each sending 2-beat packets, i_out_ready=1 -> output order 0,0,1,1,2,2,3,3; o_busy drops for 1 cycle between packets.
REQ-030 Backpressure: 4-beat packet from requester 1 with i_out_ready=0 for 3 cycles mid-packet -> o_req_ready[1]=0 while o_out_valid=1; all 4 beats arrive in order, unchanged, with no duplication.
REQ-031 Valid gap: requester 3 deasserts valid for 2 cycles mid-packet while requester 0 is valid -> o_sel stays 3 and o_req_ready[0]=0 until requester 3's last beat.
REQ-032 Reset mid-packet: i_rst=1 during beat 2 of a 4-beat packet from requester 2, with all requesters valid after reset -> all outputs match REQ-026; the next grant is requester 0.
REQ-033 Simultaneous drain and load: o_out_valid=1, i_out_ready=1, next beat transferring -> o_out_valid stays 1 and o_out_data updates on the same edge.
